// File: rtl/tx_arbiter_if.sv
// ============================================================================
// if_dev_tx_pipe : handshake bundle into the shared UART transmit pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

interface if_dev_tx_pipe #(
  parameter int WIDTH = 8
);
  logic             rst;
  logic             push_back;
  logic [WIDTH-1:0] data_in;
  logic             full;

  modport arb (
    output rst,
    output push_back,
    output data_in,
    input  full
  );

  modport pipe (
    input  rst,
    input  push_back,
    input  data_in,
    output full
  );
endinterface

`default_nettype wire

// File: rtl/tx_arbiter.sv
// ============================================================================
// tx_arbiter : round-robin drain of two requester FIFOs into dev_tx_pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module tx_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         a_valid,
  input  logic [WIDTH-1:0]             a_data,
  output logic                         a_ready,
  input  logic                         b_valid,
  input  logic [WIDTH-1:0]             b_data,
  output logic                         b_ready,
  input  logic                         flush,
  output logic [$clog2(BUF_DEPTH):0]   a_level,
  output logic [$clog2(BUF_DEPTH):0]   b_level,
  output logic                         busy,
  if_dev_tx_pipe.arb                   tx_pipe
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PUSH   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  // Index 0 is requester A, index 1 is requester B.
  logic [1:0]       w_wr_valid;
  logic [WIDTH-1:0] w_wr_data [2];
  logic [1:0]       w_ready;
  logic [1:0]       w_pop;
  logic [1:0]       w_nonempty;
  logic [WIDTH-1:0] w_head    [2];
  logic [LW-1:0]    w_level   [2];

  state_t           r_state;
  state_t           w_next;
  logic             w_start;
  logic             w_grant_b;
  logic             r_last_b;
  logic             r_push_back;
  logic             r_pipe_rst;
  logic [WIDTH-1:0] r_data_in;

  assign w_wr_valid   = {b_valid, a_valid};
  assign w_wr_data[0] = a_data;
  assign w_wr_data[1] = b_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] r_mem [BUF_DEPTH];
      logic [PW-1:0]    r_wr_ptr;
      logic [PW-1:0]    r_rd_ptr;
      logic [LW-1:0]    r_level;
      logic             w_wr;

      assign w_ready[gi]    = rst_n && !flush && (r_level != LW'(BUF_DEPTH));
      assign w_wr           = w_wr_valid[gi] && w_ready[gi];
      assign w_head[gi]     = r_mem[r_rd_ptr];
      assign w_level[gi]    = r_level;
      assign w_nonempty[gi] = (r_level != '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_level  <= '0;
        end else if (flush) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_level  <= '0;
        end else begin
          if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
          if (w_pop[gi]) r_rd_ptr <= r_rd_ptr + PW'(1);
          case ({w_wr, w_pop[gi]})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
          endcase
        end
      end

      // Storage needs no reset; the level counter guards every read.
      always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_wr_data[gi];
      end
    end
  endgenerate

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_grant_b = 1'b0;
    w_pop     = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (!tx_pipe.full && (|w_nonempty)) begin
          w_start   = 1'b1;
          // B wins when it is alone, or on a tie after A had the last grant.
          w_grant_b = w_nonempty[1] && (!w_nonempty[0] || !r_last_b);
          w_pop     = w_grant_b ? 2'b10 : 2'b01;
          w_next    = S_PUSH;
        end
      end
      S_PUSH:   w_next = S_SETTLE;
      S_SETTLE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_push_back <= 1'b0;
      r_pipe_rst  <= 1'b0;
      r_data_in   <= '0;
      r_last_b    <= 1'b1;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_push_back <= 1'b0;
      r_pipe_rst  <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_push_back <= w_start;
      r_pipe_rst  <= 1'b0;
      if (w_start) begin
        r_data_in <= w_grant_b ? w_head[1] : w_head[0];
        r_last_b  <= w_grant_b;
      end
    end
  end

  assign a_ready = w_ready[0];
  assign b_ready = w_ready[1];
  assign a_level = w_level[0];
  assign b_level = w_level[1];
  assign busy    = (r_state != S_IDLE) || (|w_nonempty);

  assign tx_pipe.rst       = r_pipe_rst;
  assign tx_pipe.push_back = r_push_back;
  assign tx_pipe.data_in   = r_data_in;

endmodule

`default_nettype wire

// File: tb/tb_tx_arbiter.sv
// ============================================================================
// tb_tx_arbiter : directed stimulus with a push scoreboard for tx_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tx_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       flush;
  logic [1:0] a_level;
  logic [1:0] b_level;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t sb[$];

  if_dev_tx_pipe #(.WIDTH(8)) pipe ();

  tx_arbiter #(.WIDTH(8), .BUF_DEPTH(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .flush   (flush),
    .a_level (a_level),
    .b_level (b_level),
    .busy    (busy),
    .tx_pipe (pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && busy; i++) tick();
    check(name, {31'd0, busy}, 32'd0);
    check({name, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  // Monitor: every push must match the head of the scoreboard.
  initial begin
    int   n;
    int   last_n;
    logic prev;
    exp_t e;
    n      = 0;
    last_n = -100;
    prev   = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (pipe.push_back === 1'b1) begin
        check("push_spacing", {31'd0, prev}, 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_push: got data 0x%0h expected no push at %0t", pipe.data_in, $time);
        end else begin
          e = sb.pop_front();
          check("push_data", {24'd0, pipe.data_in}, {24'd0, e.data});
          if (e.gap != 0) check("push_gap", n - last_n, e.gap);
        end
        last_n = n;
      end
      prev = pipe.push_back;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    a_data    = 8'h00;
    b_valid   = 1'b0;
    b_data    = 8'h00;
    flush     = 1'b0;
    pipe.full = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_a_level", {30'd0, a_level}, 32'd0);
    check("rst_b_level", {30'd0, b_level}, 32'd0);
    check("rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("rst_b_ready", {31'd0, b_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_push_back", {31'd0, pipe.push_back}, 32'd0);
    check("rst_pipe_rst", {31'd0, pipe.rst}, 32'd0);
    check("rst_data_in", {24'd0, pipe.data_in}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_a_ready", {31'd0, a_ready}, 32'd1);
    check("rel_b_ready", {31'd0, b_ready}, 32'd1);

    // Contention at startup: A wins the first tie, then strict alternation
    expect_push(8'h41, 0);
    expect_push(8'h42, 3);
    expect_push(8'h43, 3);
    expect_push(8'h44, 3);
    a_valid = 1'b1; a_data = 8'h41;
    b_valid = 1'b1; b_data = 8'h42;
    tick();
    a_data = 8'h43; b_data = 8'h44;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("cont_b_level", {30'd0, b_level}, 32'd2);
    wait_idle("cont_idle");

    // Single byte latency
    expect_push(8'h41, 0);
    a_valid = 1'b1; a_data = 8'h41;
    tick();
    a_valid = 1'b0;
    check("single_level_k", {30'd0, a_level}, 32'd1);
    check("single_pb_k", {31'd0, pipe.push_back}, 32'd0);
    tick();
    check("single_pb_k1", {31'd0, pipe.push_back}, 32'd1);
    check("single_data_k1", {24'd0, pipe.data_in}, 32'h41);
    check("single_level_k1", {30'd0, a_level}, 32'd0);
    tick();
    check("single_pb_k2", {31'd0, pipe.push_back}, 32'd0);
    check("single_busy_k2", {31'd0, busy}, 32'd1);
    tick();
    check("single_busy_k3", {31'd0, busy}, 32'd0);
    wait_idle("single_idle");

    // Backpressure: full holds everything in the FIFO
    pipe.full = 1'b1;
    a_valid = 1'b1; a_data = 8'h60;
    #1 check("bp_ready0", {31'd0, a_ready}, 32'd1);
    tick();
    a_data = 8'h61;
    check("bp_ready1", {31'd0, a_ready}, 32'd1);
    tick();
    a_data = 8'h62;
    check("bp_ready2", {31'd0, a_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    check("bp_level", {30'd0, a_level}, 32'd2);
    repeat (4) tick();
    check("bp_level_hold", {30'd0, a_level}, 32'd2);
    expect_push(8'h60, 0);
    expect_push(8'h61, 3);
    pipe.full = 1'b0;
    wait_idle("bp_idle");

    // Lone requester B
    expect_push(8'h10, 0);
    expect_push(8'h11, 3);
    expect_push(8'h12, 3);
    b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_data = 8'h10 + 8'(i);
      check("lone_ready", {31'd0, b_ready}, 32'd1);
      tick();
    end
    b_valid = 1'b0;
    wait_idle("lone_idle");

    // Flush with a_level=2, b_level=1
    pipe.full = 1'b1;
    a_valid = 1'b1; a_data = 8'h70;
    b_valid = 1'b1; b_data = 8'h80;
    tick();
    a_data = 8'h71; b_valid = 1'b0;
    tick();
    a_valid = 1'b0;
    check("fl_pre_a", {30'd0, a_level}, 32'd2);
    check("fl_pre_b", {30'd0, b_level}, 32'd1);
    flush = 1'b1; a_valid = 1'b1; a_data = 8'h72;
    #1 check("fl_a_ready", {31'd0, a_ready}, 32'd0);
    tick();
    flush = 1'b0; a_valid = 1'b0;
    check("fl_a_level", {30'd0, a_level}, 32'd0);
    check("fl_b_level", {30'd0, b_level}, 32'd0);
    check("fl_pipe_rst1", {31'd0, pipe.rst}, 32'd1);
    check("fl_push_back", {31'd0, pipe.push_back}, 32'd0);
    tick();
    check("fl_pipe_rst2", {31'd0, pipe.rst}, 32'd0);
    pipe.full = 1'b0;
    repeat (6) tick();
    check("fl_post_level", {30'd0, a_level}, 32'd0);
    wait_idle("fl_idle");

    // Asynchronous reset in the middle of a push
    expect_push(8'h55, 0);
    a_valid = 1'b1; a_data = 8'h55;
    tick();
    a_data = 8'h56;
    tick();
    a_valid = 1'b0;
    check("mid_pb", {31'd0, pipe.push_back}, 32'd1);
    check("mid_level", {30'd0, a_level}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_pb", {31'd0, pipe.push_back}, 32'd0);
    check("mid_rst_a_level", {30'd0, a_level}, 32'd0);
    check("mid_rst_b_level", {30'd0, b_level}, 32'd0);
    check("mid_rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("mid_rst_b_ready", {31'd0, b_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_a_ready", {31'd0, a_ready}, 32'd1);
    check("mid_rel_b_ready", {31'd0, b_ready}, 32'd1);
    repeat (6) tick();
    wait_idle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
